reduce_vector_unit: RTL and testbench
=====================================

// Module: reduce_vector_unit
// PURPOSE
//  Multi-lane vector reduction engine. On start it snapshots an N-element signed vector
//  and folds it LANES elements per cycle into sum, OR, AND, XOR, min and max, with the
//  index of the min/max element. All reductions run in parallel; sel picks what drives
//  the shared tri-state result bus. Sits on the accelerator result bus beside the
//  element-wise vector ALU.
// PARAMETERS
//  BITS      8                   element width, signed two's complement
//  N         64                  vector length; N % LANES == 0 (elaboration $error otherwise)
//  LANES     4                   elements consumed per cycle; 1 <= LANES <= N
//  ACC_BITS  BITS+$clog2(N)      result width; sum never overflows
// PORTS
//  clk    in   1                   single clock, rising edge
//  rst    in   1                   reset, asynchronous, active-high
//  in     in   BITS x [N-1:0]      signed input vector, sampled only on accepted start
//  sel    in   3                   result select (see BEHAVIOUR), live mux, not latched
//  start  in   1                   begin reduction; accepted in IDLE or DONE only
//  en     in   1                   bus drive enable
//  out    out  ACC_BITS signed     selected result; 'z when en=0
//  idx    out  $clog2(N)           min (sel 110) / max (sel 111) index, else 0; 'z when en=0
//  busy   out  1                   reduction in progress
//  done   out  1                   results valid; held until next accepted start or rst
// BEHAVIOUR
//  FSM IDLE -> RUN on start; RUN -> DONE after last beat; DONE -> RUN on start.
//  Accepted start at edge k: snapshot in[], clear accumulators, beat=0, busy=1, done=0.
//  RUN: each edge folds in_saved[beat*LANES +: LANES] via the lane tree into the
//    accumulators; beat increments. Last beat (N/LANES-1) at edge k+N/LANES: busy=0, done=1.
//  Latency start->done = N/LANES cycles. start in RUN ignored. Input changes after the
//    start edge do not affect results.
//  Accumulator init / reset: sum=0, or=0, and=all ones, xor=0, min=+max(BITS),
//    max=-max(BITS), min_idx=max_idx=0.
//  min/max: independent strict compares (not else-if). Ties keep the lowest index,
//    within a beat and across beats.
//  sel: 000 sum (sign-extended), 001 OR, 010 AND, 011 XOR (bitwise results zero-extended
//    to ACC_BITS), 100 min, 101 max (sign-extended), 110 min with idx, 111 max with idx.
//  out/idx are a combinational function of sel, en and accumulators. Mid-RUN they show
//    partial values; consumers qualify with done.
//  rst (any state, incl. mid-RUN): immediately busy=0, done=0, FSM=IDLE, accumulators
//    to init values, snapshot cleared to 0. Release is synchronous to clk, no spurious start.
// STRUCTURE
//  Package reduce_pkg: typedef enum logic[2:0] reduce_sel_e (REDUCE_SUM..REDUCE_ARGMAX),
//    typedef enum {S_IDLE,S_RUN,S_DONE} reduce_state_e.
//  Sub-module reduce_lane_tree #(BITS,LANES,ACC_BITS): combinational fold of one beat.
//    Gives partial sum/or/and/xor/min/max plus local lane index (lowest on ties).
//    Top owns snapshot, FSM, beat counter, accumulators and output mux.
// TESTING (BITS=8, N=8, LANES=4 unless noted)
//  in={1..8}, start, sel=000 -> busy 2 cycles, done at start+2, out=36; sel=001 out=15.
//  in={5,-3,7,-3,7,0,0,0} -> sel=110 out=-3 idx=1; sel=111 out=7 idx=2.
//  All 127 -> sum 1016; all -128 -> sum -1024 (ACC_BITS=11), min=max=-128 idx=0.
//  in={0F,F0,FF,01,0F,F0,FF,01}: OR=FF, AND=00, XOR=00 (zero-extended).
//  Change in[] and pulse start during RUN -> ignored, result per the first snapshot.
//    en=0 -> out/idx 'z.
//  rst mid-RUN (beat 1) -> busy/done 0 before next edge. Restart -> correct result.
//    LANES=1 -> done at start+8.

Source files
------------

// File: rtl/reduce_vector_unit_pkg.sv
// Shared types for the vector reduction engine: result-select codes and FSM states.
package reduce_pkg;

  typedef enum logic [2:0] {
    REDUCE_SUM    = 3'b000,
    REDUCE_OR     = 3'b001,
    REDUCE_AND    = 3'b010,
    REDUCE_XOR    = 3'b011,
    REDUCE_MIN    = 3'b100,
    REDUCE_MAX    = 3'b101,
    REDUCE_ARGMIN = 3'b110,
    REDUCE_ARGMAX = 3'b111
  } reduce_sel_e;

  typedef enum {S_IDLE, S_RUN, S_DONE} reduce_state_e;

endpackage

// File: rtl/reduce_vector_unit_if.sv
// Control/vector bundle between the accelerator sequencer and the reduction engine.
interface reduce_vector_unit_if #(
  parameter int BITS = 8,
  parameter int N    = 64
);
  logic [N-1:0][BITS-1:0] in;
  logic [2:0]             sel;
  logic                   start;
  logic                   en;
  logic                   busy;
  logic                   done;

  modport master (output in, sel, start, en, input busy, done);
  modport slave  (input in, sel, start, en, output busy, done);
endinterface

// File: rtl/reduce_vector_unit_lane_tree.sv
// Combinational fold of one beat of LANES signed elements into partial reductions.
module reduce_lane_tree
  import reduce_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int LANES    = 4,
  parameter int ACC_BITS = 11,
  parameter int LIDX_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0][BITS-1:0] lanes,
  output logic signed [ACC_BITS-1:0] part_sum,
  output logic [BITS-1:0]            part_or,
  output logic [BITS-1:0]            part_and,
  output logic [BITS-1:0]            part_xor,
  output logic signed [BITS-1:0]     part_min,
  output logic signed [BITS-1:0]     part_max,
  output logic [LIDX_W-1:0]          part_min_idx,
  output logic [LIDX_W-1:0]          part_max_idx
);

  logic signed [BITS-1:0] elem;

  // Strict compares scanning upward keep the lowest lane on ties.
  always_comb begin
    part_sum     = '0;
    part_or      = '0;
    part_and     = '1;
    part_xor     = '0;
    part_min     = $signed(lanes[0]);
    part_max     = $signed(lanes[0]);
    part_min_idx = '0;
    part_max_idx = '0;
    elem         = '0;
    for (int i = 0; i < LANES; i++) begin
      elem     = $signed(lanes[i]);
      part_sum = part_sum + ACC_BITS'(elem);
      part_or  = part_or | lanes[i];
      part_and = part_and & lanes[i];
      part_xor = part_xor ^ lanes[i];
      if (elem < part_min) begin
        part_min     = elem;
        part_min_idx = LIDX_W'(i);
      end
      if (elem > part_max) begin
        part_max     = elem;
        part_max_idx = LIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reduce_vector_unit.sv
// Multi-lane vector reduction engine driving a shared tri-state result bus.
module reduce_vector_unit
  import reduce_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int N        = 64,
  parameter int LANES    = 4,
  parameter int ACC_BITS = BITS + $clog2(N),
  localparam int IDX_W   = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  reduce_vector_unit_if.slave        bus,
  output logic signed [ACC_BITS-1:0] out,
  output logic [IDX_W-1:0]           idx
);

  localparam int NBEATS = N / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic signed [BITS-1:0] MIN_INIT  = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] MAX_INIT  = {1'b1, {(BITS-1){1'b0}}};

  if ((LANES < 1) || (LANES > N) || ((N % LANES) != 0)) begin : g_param_check
    $error("reduce_vector_unit: N must be a multiple of LANES with 1 <= LANES <= N");
  end

  reduce_state_e state, state_nxt;
  logic [N-1:0][BITS-1:0]     in_saved;
  logic [BEAT_W-1:0]          beat;
  logic signed [ACC_BITS-1:0] acc_sum;
  logic [BITS-1:0]            acc_or, acc_and, acc_xor;
  logic signed [BITS-1:0]     acc_min, acc_max;
  logic [IDX_W-1:0]           min_idx, max_idx;

  logic [LANES-1:0][BITS-1:0] beat_lanes;
  logic signed [ACC_BITS-1:0] part_sum;
  logic [BITS-1:0]            part_or, part_and, part_xor;
  logic signed [BITS-1:0]     part_min, part_max;
  logic [LIDX_W-1:0]          part_min_idx, part_max_idx;
  logic [IDX_W-1:0]           beat_base;
  logic                       start_acc;
  logic signed [ACC_BITS-1:0] result;
  logic [IDX_W-1:0]           result_idx;

  assign start_acc  = bus.start && (state != S_RUN);
  assign beat_lanes = in_saved[int'(beat)*LANES +: LANES];
  assign beat_base  = IDX_W'(int'(beat) * LANES);

  reduce_lane_tree #(
    .BITS(BITS), .LANES(LANES), .ACC_BITS(ACC_BITS)
  ) u_lane_tree (
    .lanes(beat_lanes), .part_sum(part_sum),
    .part_or(part_or), .part_and(part_and), .part_xor(part_xor),
    .part_min(part_min), .part_max(part_max),
    .part_min_idx(part_min_idx), .part_max_idx(part_max_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (beat == LAST_BEAT) state_nxt = S_DONE;
      S_DONE:  if (bus.start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == S_RUN);
    bus.done = (state == S_DONE);
  end

  // Cross-beat compares are strict too, so an earlier beat wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_saved <= '0;
      beat     <= '0;
      acc_sum  <= '0;
      acc_or   <= '0;
      acc_and  <= '1;
      acc_xor  <= '0;
      acc_min  <= MIN_INIT;
      acc_max  <= MAX_INIT;
      min_idx  <= '0;
      max_idx  <= '0;
    end else if (start_acc) begin
      in_saved <= bus.in;
      beat     <= '0;
      acc_sum  <= '0;
      acc_or   <= '0;
      acc_and  <= '1;
      acc_xor  <= '0;
      acc_min  <= MIN_INIT;
      acc_max  <= MAX_INIT;
      min_idx  <= '0;
      max_idx  <= '0;
    end else if (state == S_RUN) begin
      beat    <= beat + BEAT_W'(1);
      acc_sum <= acc_sum + part_sum;
      acc_or  <= acc_or | part_or;
      acc_and <= acc_and & part_and;
      acc_xor <= acc_xor ^ part_xor;
      if (part_min < acc_min) begin
        acc_min <= part_min;
        min_idx <= beat_base + IDX_W'(part_min_idx);
      end
      if (part_max > acc_max) begin
        acc_max <= part_max;
        max_idx <= beat_base + IDX_W'(part_max_idx);
      end
    end
  end

  always_comb begin
    result     = '0;
    result_idx = '0;
    case (reduce_sel_e'(bus.sel))
      REDUCE_SUM:    result = acc_sum;
      REDUCE_OR:     result = ACC_BITS'($unsigned(acc_or));
      REDUCE_AND:    result = ACC_BITS'($unsigned(acc_and));
      REDUCE_XOR:    result = ACC_BITS'($unsigned(acc_xor));
      REDUCE_MIN:    result = ACC_BITS'(acc_min);
      REDUCE_MAX:    result = ACC_BITS'(acc_max);
      REDUCE_ARGMIN: begin result = ACC_BITS'(acc_min); result_idx = min_idx; end
      REDUCE_ARGMAX: begin result = ACC_BITS'(acc_max); result_idx = max_idx; end
      default:       result = '0;
    endcase
  end

  assign out = bus.en ? result     : 'z;
  assign idx = bus.en ? result_idx : 'z;

endmodule

// File: tb/tb_reduce_vector_unit.sv
// Randomized scoreboard bench for reduce_vector_unit (N=8, LANES=4) plus a LANES=1 latency check.
module tb_reduce_vector_unit;
  import reduce_pkg::*;

  localparam int BITS = 8;
  localparam int N    = 8;
  localparam int ACC  = BITS + $clog2(N);
  localparam int IW   = $clog2(N);

  typedef logic [N-1:0][BITS-1:0] vec_t;
  typedef struct {
    int sum, ior, iand, ixor, mn, mx, mn_i, mx_i;
  } exp_t;

  logic clk, rst;
  int   total, bad;
  int   req_cnt, served_cnt;
  exp_t sb[$];

  reduce_vector_unit_if #(.BITS(BITS), .N(N)) bus_a ();
  reduce_vector_unit_if #(.BITS(BITS), .N(N)) bus_b ();
  wire signed [ACC-1:0] out_a, out_b;
  wire [IW-1:0]         idx_a, idx_b;

  reduce_vector_unit #(.BITS(BITS), .N(N), .LANES(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .out(out_a), .idx(idx_a)
  );
  reduce_vector_unit #(.BITS(BITS), .N(N), .LANES(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .out(out_b), .idx(idx_b)
  );

  initial clk = 0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference reduction straight from the arithmetic definition.
  function automatic exp_t model(vec_t v);
    exp_t r;
    int   e;
    r.sum = 0; r.ior = 0; r.iand = (1 << BITS) - 1; r.ixor = 0;
    r.mn = 0; r.mx = 0; r.mn_i = 0; r.mx_i = 0;
    for (int i = 0; i < N; i++) begin
      e = int'($signed(v[i]));
      r.sum  += e;
      r.ior  |= int'(v[i]);
      r.iand &= int'(v[i]);
      r.ixor ^= int'(v[i]);
      if (i == 0 || e < r.mn) begin r.mn = e; r.mn_i = i; end
      if (i == 0 || e > r.mx) begin r.mx = e; r.mx_i = i; end
    end
    return r;
  endfunction

  function automatic vec_t from_ints(input int v[N]);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = 8'(v[i]);
    return r;
  endfunction

  function automatic exp_t reset_exp();
    exp_t r;
    r.sum = 0; r.ior = 0; r.iand = 255; r.ixor = 0;
    r.mn = 127; r.mx = -128; r.mn_i = 0; r.mx_i = 0;
    return r;
  endfunction

  // Monitor: owns sel/en, checks every result view whenever done rises or a check is requested.
  initial begin : monitor
    exp_t e;
    int   exp_out[8];
    int   exp_idx[8];
    bit   done_q;
    bus_a.sel = 3'b000;
    bus_a.en  = 1'b1;
    done_q    = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus_a.done && !done_q) || (req_cnt != served_cnt)) begin
        if (req_cnt != served_cnt) served_cnt++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_result actual=done required=no_pending");
        end else begin
          e = sb[0];
          exp_out = '{e.sum, e.ior, e.iand, e.ixor, e.mn, e.mx, e.mn, e.mx};
          exp_idx = '{0, 0, 0, 0, 0, 0, e.mn_i, e.mx_i};
          for (int s = 0; s < 8; s++) begin
            bus_a.sel = 3'(s);
            #1;
            checkOutput($sformatf("out_sel%0d", s), int'(out_a), exp_out[s]);
            checkOutput($sformatf("idx_sel%0d", s), int'(idx_a), exp_idx[s]);
          end
          if (e.mn != 0) begin
            bus_a.sel = REDUCE_ARGMIN;
            bus_a.en  = 1'b0;
            #1;
            total++;
            if (!((out_a === 'z || out_a === '0) && (idx_a === 'z || idx_a === '0))) begin
              bad++;
              $display("[TB] FAIL bus_release actual=%h/%h required=z", out_a, idx_a);
            end
            bus_a.en = 1'b1;
          end
          void'(sb.pop_front());
        end
      end
      done_q = bus_a.done;
    end
  end

  task automatic drain(input string name);
    for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL %s actual=%0d_pending required=0", name, sb.size());
      sb.delete();
    end
  endtask

  // Issue one reduction on dut_a; optionally disturb in[] and re-pulse start during RUN.
  task automatic applyStimulus(input vec_t vec, input bit disturb);
    int cycles;
    bus_a.in    = vec;
    bus_a.start = 1'b1;
    sb.push_back(model(vec));
    @(posedge clk);
    cycles = 0;
    @(negedge clk);
    checkOutput("busy_after_start", int'(bus_a.busy), 1);
    checkOutput("done_after_start", int'(bus_a.done), 0);
    if (disturb) bus_a.in = vec_t'({$urandom, $urandom});
    else         bus_a.start = 1'b0;
    while (!bus_a.done && cycles < 100) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    checkOutput("latency_lanes4", cycles, N / 4);
    drain("scoreboard_drain");
    checkOutput("done_held", int'(bus_a.done), 1);
  endtask

  task automatic runLanes1(input vec_t vec);
    int   cycles;
    exp_t e;
    e = model(vec);
    bus_b.in    = vec;
    bus_b.start = 1'b1;
    @(posedge clk);
    cycles = 0;
    @(negedge clk);
    bus_b.start = 1'b0;
    while (!bus_b.done && cycles < 100) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    checkOutput("latency_lanes1", cycles, N);
    bus_b.sel = REDUCE_SUM;    #1; checkOutput("lanes1_sum", int'(out_b), e.sum);
    bus_b.sel = REDUCE_ARGMAX; #1; checkOutput("lanes1_maxidx", int'(idx_b), e.mx_i);
  endtask

  function automatic vec_t random_vec();
    vec_t v;
    bit   narrow;
    narrow = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++)
      v[i] = narrow ? 8'($urandom_range(0, 4) - 2) : 8'($urandom);
    return v;
  endfunction

  initial begin : stimulus
    int vals[N];
    total = 0; bad = 0; req_cnt = 0; served_cnt = 0;
    rst = 1'b1;
    bus_a.in = '0; bus_a.start = 1'b0;
    bus_b.in = '0; bus_b.start = 1'b0; bus_b.sel = 3'b000; bus_b.en = 1'b1;
    #5;
    checkOutput("reset_busy", int'(bus_a.busy), 0);
    checkOutput("reset_done", int'(bus_a.done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(reset_exp());
    req_cnt++;
    drain("reset_state_drain");

    vals = '{1, 2, 3, 4, 5, 6, 7, 8};             applyStimulus(from_ints(vals), 1'b0);
    vals = '{5, -3, 7, -3, 7, 0, 0, 0};           applyStimulus(from_ints(vals), 1'b0);
    vals = '{127, 127, 127, 127, 127, 127, 127, 127};
    applyStimulus(from_ints(vals), 1'b0);
    vals = '{-128, -128, -128, -128, -128, -128, -128, -128};
    applyStimulus(from_ints(vals), 1'b0);
    vals = '{'h0F, 'hF0, 'hFF, 'h01, 'h0F, 'hF0, 'hFF, 'h01};
    applyStimulus(from_ints(vals), 1'b0);
    vals = '{9, -1, 4, 60, -70, 3, 3, 2};         applyStimulus(from_ints(vals), 1'b1);

    // Reset in the middle of RUN, then restart.
    vals = '{10, 20, 30, 40, 50, 60, 70, 80};
    bus_a.in    = from_ints(vals);
    bus_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrun_rst_busy", int'(bus_a.busy), 0);
    checkOutput("midrun_rst_done", int'(bus_a.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("no_spurious_start", int'(bus_a.busy), 0);
    sb.push_back(reset_exp());
    req_cnt++;
    drain("post_rst_drain");
    applyStimulus(from_ints(vals), 1'b0);

    for (int t = 0; t < 20; t++) applyStimulus(random_vec(), t[0]);

    vals = '{1, 2, 3, 4, 5, 6, 7, 8};             runLanes1(from_ints(vals));
    vals = '{-5, 9, 9, -100, 0, 9, 1, 2};         runLanes1(from_ints(vals));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
